// File: rtl/gf2_pkg.sv
// gf2_pkg: widths, FSM state encodings and degree-width helper for the GF(2)[x] divider
package gf2_pkg;
  localparam int N = 163;
  localparam int M = 82;
  localparam int CW = 8;
  function automatic int deg_w();
    return $clog2(M);
  endfunction
  localparam int DW = deg_w();
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] DIV = 2'd2;
  localparam logic [1:0] OUT = 2'd3;
endpackage

// File: rtl/gf2_deg_find.sv
// gf2_deg_find: combinational priority encoder giving the highest set bit index and a zero flag
module gf2_deg_find
  import gf2_pkg::*;
(
  input  logic [M-1:0]  v,
  output logic [DW-1:0] idx,
  output logic          zero
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < M; i++) if (v[i]) idx = DW'(i);
    zero = ~|v;
  end
endmodule

// File: rtl/gf2_poly_div_163.sv
// gf2_poly_div_163: bit-serial GF(2)[x] long divider, 163-bit dividend by 82-bit divisor
module gf2_poly_div_163
  import gf2_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_in,
  input  logic [M-1:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q_out,
  output logic [M-2:0] r_out,
  output logic         div_zero
);
  logic [1:0] state_q, state_d;
  logic [N-1:0] a_q, a_d, quo_q, quo_d, q_out_q, q_out_d;
  logic [M-1:0] b_q, b_d, rem_q, rem_d;
  logic [M-2:0] r_out_q, r_out_d;
  logic [DW-1:0] d_q, d_d, deg;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dz_q, dz_d, b_zero, fire;
  logic [M-1:0] t, step_rem;
  logic [N-1:0] step_quo;
  gf2_deg_find u_deg (.v(b_q), .idx(deg), .zero(b_zero));
  assign t = {rem_q[M-2:0], a_q[N-1]};
  assign fire = t[d_q];
  assign step_rem = fire ? t ^ b_q : t;
  assign step_quo = {quo_q[N-2:0], fire};
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == OUT;
  assign q_out = q_out_q;
  assign r_out = r_out_q;
  assign div_zero = dz_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    rem_d = rem_q;
    quo_d = quo_q;
    d_d = d_q;
    cnt_d = cnt_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dz_d = dz_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a_in;
        b_d = b_in;
        rem_d = '0;
        quo_d = '0;
        state_d = PREP;
      end
      PREP: begin
        d_d = deg;
        cnt_d = CW'(N - 1);
        state_d = b_zero ? OUT : DIV;
        dz_d = b_zero;
        q_out_d = b_zero ? '0 : q_out_q;
        r_out_d = b_zero ? '0 : r_out_q;
      end
      DIV: begin
        a_d = a_q << 1;
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          q_out_d = step_quo;
          r_out_d = step_rem[M-2:0];
          dz_d = 1'b0;
          state_d = OUT;
        end
      end
      OUT: state_d = out_ready ? IDLE : OUT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dz_q <= dz_d;
    end
  end
endmodule
